// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Central stall/flush controller for a classic 5-stage pipeline. It arbitrates
//   the pipeline events in a fixed priority order:
//     halt > data-memory wait > taken branch > load-use > instruction miss.
//   For the winning event it drives the per-register enable and flush controls
//   in the same cycle. The only registered element is the controller state
//   (plus the optional statistics counters).
//
// Optional feature:
//   HAZARD_STATS_EN - when defined, adds the stall_cnt and flush_cnt outputs.
//                     Both counters saturate at 32'hFFFFFFFF.
//
// Ports:
//   CLK                 in   pipeline clock, rising edge
//   RST                 in   synchronous active-high reset
//   idex_dren           in   instruction in EX is a load
//   idex_regWrite       in   instruction in EX writes a register (not needed:
//                            a load always writes its rt)
//   idex_rt[4:0]        in   destination register of the instruction in EX
//   dec_rs[4:0]         in   rs operand of the instruction in decode
//   dec_rt[4:0]         in   rt operand of the instruction in decode
//   dec_uses_rt         in   the decode instruction actually reads rt
//   ihit                in   instruction fetch hit
//   exmem_dren          in   MEM stage data read request
//   exmem_dwen          in   MEM stage data write request
//   dhit                in   data memory has completed the access
//   mem_branch_taken    in   branch resolved taken in MEM
//   wb_halt             in   halt instruction reached WB
//   pc_en .. memwb_en   out  pipeline register enables / flushes
//   halted              out  controller is in HALT
//   state[2:0]          out  current state: RUN=0 LOADUSE=1 BRFLUSH=2
//                            MEMWAIT=3 HALT=4
//   stall_cnt[31:0]     out  cycles with pc_en=0 outside HALT (stats build)
//   flush_cnt[31:0]     out  taken-branch flushes (stats build)
// -----------------------------------------------------------------------------
module hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        idex_dren,
  input  logic        idex_regWrite,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic        dec_uses_rt,
  input  logic        ihit,
  input  logic        exmem_dren,
  input  logic        exmem_dwen,
  input  logic        dhit,
  input  logic        mem_branch_taken,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        memwb_en,
  output logic        halted,
  output logic [2:0]  state
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    LOADUSE = 3'd1,
    BRFLUSH = 3'd2,
    MEMWAIT = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic   dwait;
  logic   load_use;

  // A load always writes its rt, so regWrite carries no extra information here.
  logic   unused_inputs;
  assign unused_inputs = idex_regWrite;

  // Data-memory access outstanding: the whole pipeline must freeze.
  assign dwait = (exmem_dren | exmem_dwen) & ~dhit;

  // Register 0 is hard-wired zero, so a load into it cannot create a hazard.
  assign load_use = idex_dren && (idex_rt != 5'd0) &&
                    ((idex_rt == dec_rs) || (dec_uses_rt && (idex_rt == dec_rt)));

  // Mealy decode of the current state and inputs. Each branch describes one
  // event; the order of the if-chain is the event priority. A flushed
  // register always has its enable low so the two never conflict.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d     = RUN;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;

    if (RST) begin
      // Hold every register and clear every flushable one while in reset.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      exmem_flush = 1'b1;
      memwb_en    = 1'b0;
      state_d     = RUN;
    end else if (state_q == HALT || wb_halt) begin
      // Freeze everything; HALT is only left through RST.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = HALT;
    end else if (dwait) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = MEMWAIT;
    end else if (mem_branch_taken) begin
      // Kill the three younger instructions; PC loads the branch target.
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      exmem_flush = 1'b1;
      state_d     = BRFLUSH;
    end else if (load_use) begin
      // Hold fetch/decode, insert a bubble into EX, let the load proceed.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      idex_flush = 1'b1;
      state_d    = LOADUSE;
    end else if (!ihit) begin
      // Fetch missed: hold PC, feed a bubble into decode, drain the rest.
      // LOADUSE/BRFLUSH/MEMWAIT are one-shot, so the miss returns to RUN.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      state_d    = RUN;
    end
  end

  assign halted = (state_q == HALT) && !RST;
  assign state  = state_q;

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!pc_en && state_q != HALT && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (state_d == BRFLUSH && flush_cnt != 32'hFFFF_FFFF) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed scenarios followed by randomized traffic, all compared against a
// reference model that classifies each cycle into one pipeline event and
// looks up what each pipeline register should do for that event.
// Define HAZARD_STATS_EN for both files to also check the counters.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       idex_dren;
    logic       idex_regWrite;
    logic [4:0] idex_rt;
    logic [4:0] dec_rs;
    logic [4:0] dec_rt;
    logic       dec_uses_rt;
    logic       ihit;
    logic       exmem_dren;
    logic       exmem_dwen;
    logic       dhit;
    logic       mem_branch_taken;
    logic       wb_halt;
  } in_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        idex_dren, idex_regWrite, dec_uses_rt, ihit;
  logic [4:0]  idex_rt, dec_rs, dec_rt;
  logic        exmem_dren, exmem_dwen, dhit, mem_branch_taken, wb_halt;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, halted;
  logic [2:0]  state;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int m_state     = 0;   // model state: 0 RUN 1 LOADUSE 2 BRFLUSH 3 MEMWAIT 4 HALT

  always #5 CLK = ~CLK;

  hazard_ctrl dut (
    .CLK              (CLK),
    .RST              (RST),
    .idex_dren        (idex_dren),
    .idex_regWrite    (idex_regWrite),
    .idex_rt          (idex_rt),
    .dec_rs           (dec_rs),
    .dec_rt           (dec_rt),
    .dec_uses_rt      (dec_uses_rt),
    .ihit             (ihit),
    .exmem_dren       (exmem_dren),
    .exmem_dwen       (exmem_dwen),
    .dhit             (dhit),
    .mem_branch_taken (mem_branch_taken),
    .wb_halt          (wb_halt),
    .pc_en            (pc_en),
    .ifid_en          (ifid_en),
    .ifid_flush       (ifid_flush),
    .idex_en          (idex_en),
    .idex_flush       (idex_flush),
    .exmem_en         (exmem_en),
    .exmem_flush      (exmem_flush),
    .memwb_en         (memwb_en),
    .halted           (halted),
    .state            (state)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
`endif
  );

  // Reference model. Each cycle is one event; the event fixes an action per
  // pipeline register in order pc, ifid, idex, exmem, memwb:
  // A = advance (enable), H = hold, F = flush.
  function automatic void model(input in_t i, input int st,
                                output logic [11:0] o, output int nst,
                                output bit stall, output bit brf);
    int    ev;
    string act;
    bit    hz;
    hz = i.idex_dren && i.idex_rt != 0 &&
         (i.idex_rt == i.dec_rs || (i.dec_uses_rt && i.idex_rt == i.dec_rt));
    if (i.rst)                                         ev = 7;
    else if (st == 4)                                  ev = 6;
    else if (i.wb_halt)                                ev = 5;
    else if ((i.exmem_dren || i.exmem_dwen) && !i.dhit) ev = 4;
    else if (i.mem_branch_taken)                       ev = 3;
    else if (hz)                                       ev = 2;
    else if (!i.ihit)                                  ev = 1;
    else                                               ev = 0;
    case (ev)
      7:       begin act = "HFFFH"; nst = 0; end
      6, 5:    begin act = "HHHHH"; nst = 4; end
      4:       begin act = "HHHHH"; nst = 3; end
      3:       begin act = "AFFFA"; nst = 2; end
      2:       begin act = "HHFAA"; nst = 1; end
      1:       begin act = "HFAAA"; nst = 0; end
      default: begin act = "AAAAA"; nst = 0; end
    endcase
    o = {act[0] == "A",
         act[1] == "A", act[1] == "F",
         act[2] == "A", act[2] == "F",
         act[3] == "A", act[3] == "F",
         act[4] == "A",
         ev == 6, 3'(st)};
    stall = (ev != 7) && (st != 4) && (act[0] != "A");
    brf   = (ev == 3);
  endfunction

  function automatic in_t idle();
    in_t v;
    v      = '0;
    v.ihit = 1'b1;
    v.dhit = 1'b1;
    return v;
  endfunction

  // Apply one cycle of inputs, compare the Mealy outputs mid-cycle, then
  // advance the model across the rising edge.
  task automatic step(input in_t v, input bit chk, input string tag);
    logic [11:0] exp_o, obs_o;
    int          nst;
    bit          stall, brf;
    RST = v.rst; idex_dren = v.idex_dren; idex_regWrite = v.idex_regWrite;
    idex_rt = v.idex_rt; dec_rs = v.dec_rs; dec_rt = v.dec_rt;
    dec_uses_rt = v.dec_uses_rt; ihit = v.ihit; exmem_dren = v.exmem_dren;
    exmem_dwen = v.exmem_dwen; dhit = v.dhit;
    mem_branch_taken = v.mem_branch_taken; wb_halt = v.wb_halt;
    #2;
    model(v, m_state, exp_o, nst, stall, brf);
    obs_o = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             exmem_flush, memwb_en, halted, state};
    if (chk) begin
      vectors++;
      assert (obs_o === exp_o) else begin
        miscompares++;
        $error("FAIL %s: outputs observed %b expected %b (pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb,halted,state)",
               tag, obs_o, exp_o);
      end
`ifdef HAZARD_STATS_EN
      vectors++;
      assert ({stall_cnt, flush_cnt} === {m_stall, m_flush}) else begin
        miscompares++;
        $error("FAIL %s_cnt: stall/flush observed %0d/%0d expected %0d/%0d",
               tag, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
    end
    @(posedge CLK);
    #1;
    m_state = nst;
`ifdef HAZARD_STATS_EN
    if (v.rst) begin
      m_stall = 32'd0;
      m_flush = 32'd0;
    end else begin
      if (stall && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (brf && m_flush != 32'hFFFF_FFFF)   m_flush++;
    end
`endif
  endtask

  initial begin
    in_t v;

    // First edge in reset establishes a known state.
    v = idle(); v.rst = 1'b1;
    step(v, 1'b0, "rst_init");
    step(v, 1'b1, "rst_hold");

    // Load-use on rs: stall, LOADUSE, back to RUN.
    v = idle(); v.idex_dren = 1'b1; v.idex_rt = 5'd5; v.dec_rs = 5'd5;
    step(v, 1'b1, "lu_stall");
    step(idle(), 1'b1, "lu_state");
    step(idle(), 1'b1, "lu_run");

    // Load into r0 never stalls.
    v = idle(); v.idex_dren = 1'b1; v.idex_rt = 5'd0; v.dec_rs = 5'd0;
    step(v, 1'b1, "lu_r0");

    // Load-use through rt only when rt is actually read.
    v = idle(); v.idex_dren = 1'b1; v.idex_rt = 5'd7; v.dec_rt = 5'd7;
    step(v, 1'b1, "lu_rt_unused");
    v.dec_uses_rt = 1'b1;
    step(v, 1'b1, "lu_rt_used");
    step(v, 1'b1, "lu_back_to_back");
    step(idle(), 1'b1, "lu_release");

    // Three-cycle data-memory wait.
    v = idle(); v.exmem_dren = 1'b1; v.dhit = 1'b0;
    for (int k = 0; k < 3; k++) step(v, 1'b1, "dwait");
    v.dhit = 1'b1;
    step(v, 1'b1, "dwait_done");
    step(idle(), 1'b1, "dwait_run");

    // Taken branch beats a simultaneous load-use.
    v = idle(); v.mem_branch_taken = 1'b1;
    v.idex_dren = 1'b1; v.idex_rt = 5'd3; v.dec_rs = 5'd3;
    step(v, 1'b1, "br_over_lu");
    step(idle(), 1'b1, "br_state");
    step(idle(), 1'b1, "br_run");

    // Instruction miss with a store pending but hit.
    v = idle(); v.ihit = 1'b0; v.exmem_dwen = 1'b1;
    step(v, 1'b1, "imiss");

    // Halt pulse, five sticky cycles, then reset.
    v = idle(); v.wb_halt = 1'b1;
    step(v, 1'b1, "halt_req");
    for (int k = 0; k < 5; k++) step(idle(), 1'b1, "halted");
    v = idle(); v.rst = 1'b1;
    step(v, 1'b1, "halt_rst");
    step(idle(), 1'b1, "halt_after_rst");

    // Reset abandons a memory wait immediately.
    v = idle(); v.exmem_dwen = 1'b1; v.dhit = 1'b0;
    step(v, 1'b1, "rst_mw_enter");
    v.rst = 1'b1;
    step(v, 1'b1, "rst_mw_rst");
    step(idle(), 1'b1, "rst_mw_run");

    // Randomized traffic; small register numbers make collisions common.
    for (int n = 0; n < 600; n++) begin
      v = '0;
      v.rst              = ($urandom_range(0, 29) == 0);
      v.idex_dren        = $urandom_range(0, 1);
      v.idex_regWrite    = $urandom_range(0, 1);
      v.idex_rt          = 5'($urandom_range(0, 3));
      v.dec_rs           = 5'($urandom_range(0, 3));
      v.dec_rt           = 5'($urandom_range(0, 3));
      v.dec_uses_rt      = $urandom_range(0, 1);
      v.ihit             = ($urandom_range(0, 4) != 0);
      v.exmem_dren       = ($urandom_range(0, 3) == 0);
      v.exmem_dwen       = ($urandom_range(0, 5) == 0);
      v.dhit             = ($urandom_range(0, 2) != 0);
      v.mem_branch_taken = ($urandom_range(0, 7) == 0);
      v.wb_halt          = ($urandom_range(0, 39) == 0);
      step(v, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  pipeline clock (rising edge); RST  in  1  synchronous active-high reset.
REQ-002 SHALL have inputs: idex_dren 1, idex_regWrite 1, idex_rt 5 (ID/EX register outputs); dec_rs 5, dec_rt 5, dec_uses_rt 1 (decode-stage operands); ihit 1; exmem_dren 1, exmem_dwen 1, dhit 1; mem_branch_taken 1; wb_halt 1.
REQ-003 SHALL have outputs: pc_en 1, ifid_en 1, ifid_flush 1, idex_en 1, idex_flush 1, exmem_en 1, exmem_flush 1, memwb_en 1, halted 1, state 3 (encoded state for debug).
REQ-004 Clock and reset SHALL be exactly one clock, synchronous active-high reset; no other clock or async path.

Function
REQ-005 SHALL implement FSM states RUN=0, LOADUSE=1, BRFLUSH=2, MEMWAIT=3, HALT=4; state output equals the current state.
REQ-006 Event priority SHALL be: wb_halt > data-memory wait > mem_branch_taken > load-use > ifetch miss.
REQ-007 Load-use hazard SHALL be: idex_dren=1, idex_rt!=0, and (idex_rt==dec_rs or (dec_uses_rt=1 and idex_rt==dec_rt)).
REQ-008 In RUN with load-use detected: same cycle pc_en=0, ifid_en=0, idex_flush=1, later stages enabled; next state LOADUSE.
REQ-009 LOADUSE SHALL last exactly one cycle with all enables=1 and no flushes, then return to RUN (or higher-priority state); a second load-use in that cycle is re-evaluated normally.
REQ-010 Data-memory wait SHALL be (exmem_dren|exmem_dwen)=1 and dhit=0: pc_en, ifid_en, idex_en, exmem_en, memwb_en all 0, no flushes; state MEMWAIT held until dhit=1.
REQ-011 On the dhit=1 cycle in MEMWAIT, all enables SHALL be 1 and next state RUN.
REQ-012 mem_branch_taken=1 (no wait pending) SHALL assert ifid_flush, idex_flush, exmem_flush with pc_en=1 in that cycle; next state BRFLUSH; load-use in the same cycle is ignored.
REQ-013 BRFLUSH SHALL last one cycle, no flushes, enables=1, then RUN.
REQ-014 ihit=0 (no higher event) SHALL force pc_en=0, ifid_flush=1; downstream stages keep advancing; state unchanged.
REQ-015 wb_halt=1 SHALL enter HALT next cycle; HALT is sticky until RST, all enables 0, flushes 0, halted=1.
REQ-016 Flush and enable of the same register SHALL never both be asserted; flush takes precedence when both would apply.
REQ-017 Outputs SHALL be Mealy functions of state and current inputs; only state (and stats counters) is registered.

Reset
REQ-018 With RST=1 at a rising edge, state SHALL become RUN, halted=0, counters 0.
REQ-019 While RST=1, outputs SHALL be: all enables 0, all flushes 1, halted 0.
REQ-020 RST mid-MEMWAIT or mid-HALT SHALL abandon the state immediately; no residual stall after RST deasserts.

Configuration
REQ-021 Macro HAZARD_STATS_EN defined: outputs stall_cnt 32 and flush_cnt 32 added; stall_cnt increments each cycle pc_en=0 while state!=HALT, flush_cnt increments each mem_branch_taken flush; both saturate at 32'hFFFFFFFF.
REQ-022 Macro undefined: stall_cnt and flush_cnt ports absent, no counter logic; all other behaviour identical.

Verification
REQ-023 idex_dren=1, idex_rt=5, dec_rs=5 in RUN -> cycle 0 pc_en=0, ifid_en=0, idex_flush=1; cycle 1 state=LOADUSE, all enables 1; cycle 2 RUN.
REQ-024 idex_dren=1, idex_rt=0, dec_rs=0 -> no stall, pc_en=1, state RUN.
REQ-025 exmem_dren=1, dhit=0 for 3 cycles then 1 -> 3 cycles all enables 0 in MEMWAIT, 4th cycle enables 1, then RUN.
REQ-026 mem_branch_taken=1 with simultaneous load-use -> ifid/idex/exmem_flush=1, pc_en=1, next BRFLUSH, no LOADUSE.
REQ-027 wb_halt=1 pulse, then RST after 5 cycles -> halted=1 for 5 cycles, enables 0; after RST state=RUN, halted=0.
REQ-028 With HAZARD_STATS_EN: 2 load-use stalls + 3-cycle memory wait + 1 branch -> stall_cnt=5, flush_cnt=1.
